// File: rtl/gate_scheduler_if.sv
// Bundle of signals between the gate scheduler and its surroundings.
// The scheduler uses the master view. The collision logic, gate mover and
// frog controller (or a bench standing in for them) use the slave view.
interface gate_scheduler_if;
    logic       game_active;
    logic       hit_A;
    logic       hit_B;
    logic [3:0] random;
    logic       change_coord;
    logic       teleport_req;
    logic       teleport_to_B;
    logic       gates_ready;

    modport master (
        input  game_active,
        input  hit_A,
        input  hit_B,
        output random,
        output change_coord,
        output teleport_req,
        output teleport_to_B,
        output gates_ready
    );

    modport slave (
        output game_active,
        output hit_A,
        output hit_B,
        input  random,
        input  change_coord,
        input  teleport_req,
        input  teleport_to_B,
        input  gates_ready
    );
endinterface

// File: rtl/gate_scheduler.sv
// Gate pair life-cycle controller.
// It places the gates when a round starts and moves them when they sit
// unused for too long. When the frog enters a gate it requests a teleport,
// then ignores hits for a cooldown window. After that the used gates are
// always moved.
module gate_scheduler #(
    parameter int unsigned PERIOD    = 250000000,
    parameter int unsigned COOLDOWN  = 25000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            CLK,
    input  logic            resetN,
    gate_scheduler_if.master bus
);

    localparam logic [27:0] PERIOD_LOAD   = 28'(PERIOD - 1);
    localparam logic [27:0] COOLDOWN_LOAD = 28'(COOLDOWN - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_RELOCATE,
        S_ARMED,
        S_TELEPORT,
        S_COOLDOWN
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] timer_q, timer_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  random_q, random_d;
    logic        teleport_to_b_q, teleport_to_b_d;

    logic [15:0] lfsr_next;
    logic [3:0]  cand;
    logic [3:0]  next_index;
    logic        timer_done;

    // Galois LFSR step for x^16+x^14+x^13+x^11+1. The shifted-out bit is
    // fed back into the tap positions.
    always_comb begin
        lfsr_next       = {1'b0, lfsr_q[15:1]};
        lfsr_next[15]   = lfsr_q[0];
        lfsr_next[13]   = lfsr_q[14] ^ lfsr_q[0];
        lfsr_next[12]   = lfsr_q[13] ^ lfsr_q[0];
        lfsr_next[10]   = lfsr_q[11] ^ lfsr_q[0];
    end

    // Pick the next gate position. If the candidate equals the current
    // position, bump it by one so the gates never reappear in the same place.
    always_comb begin
        cand       = lfsr_q[3:0];
        next_index = cand;
        if (cand == random_q) begin
            next_index = cand + 4'd1;
        end
    end

    assign timer_done = (timer_q == 28'd0);

    // Next-state logic. By default the timer counts down and saturates at 0.
    // A dropped game_active overrides every transition except staying in OFF.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_done ? 28'd0 : timer_q - 28'd1;
        lfsr_d          = lfsr_next;
        random_d        = random_q;
        teleport_to_b_d = teleport_to_b_q;

        case (state_q)
            S_OFF: begin
                timer_d = 28'd0;
                if (bus.game_active) begin
                    state_d = S_RELOCATE;
                end
            end
            S_RELOCATE: begin
                random_d = next_index;
                timer_d  = PERIOD_LOAD;
                state_d  = S_ARMED;
            end
            S_ARMED: begin
                if (bus.hit_A) begin
                    state_d         = S_TELEPORT;
                    teleport_to_b_d = 1'b1;
                end else if (bus.hit_B) begin
                    state_d         = S_TELEPORT;
                    teleport_to_b_d = 1'b0;
                end else if (timer_done) begin
                    state_d = S_RELOCATE;
                end
            end
            S_TELEPORT: begin
                timer_d = COOLDOWN_LOAD;
                state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (timer_done && !bus.hit_A && !bus.hit_B) begin
                    state_d = S_RELOCATE;
                end
            end
            default: begin
                state_d = S_OFF;
                timer_d = 28'd0;
            end
        endcase

        if ((state_q != S_OFF) && !bus.game_active) begin
            state_d = S_OFF;
            timer_d = 28'd0;
        end
    end

    // State, timer, LFSR and held outputs, with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetN) begin
            state_q         <= S_OFF;
            timer_q         <= 28'd0;
            lfsr_q          <= LFSR_SEED;
            random_q        <= 4'd0;
            teleport_to_b_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            lfsr_q          <= lfsr_d;
            random_q        <= random_d;
            teleport_to_b_q <= teleport_to_b_d;
        end
    end

    // The pulses and the ready flag are decoded straight from the state
    // register. They are held low while reset is asserted, so the reset
    // cycle never emits a pulse.
    assign bus.change_coord  = resetN && (state_q == S_RELOCATE);
    assign bus.teleport_req  = resetN && (state_q == S_TELEPORT);
    assign bus.gates_ready   = resetN && (state_q == S_ARMED);
    assign bus.random        = random_q;
    assign bus.teleport_to_B = teleport_to_b_q;

endmodule

// File: tb/tb_gate_scheduler.sv
// Self-checking bench for gate_scheduler, run with short PERIOD/COOLDOWN.
// A model tracks the phase and the cycles spent in it. It is compared
// against the DUT outputs on every falling edge. Directed scenarios add
// hand-computed expectations on top of that.
module tb_gate_scheduler;

    localparam int unsigned PERIOD   = 8;
    localparam int unsigned COOLDOWN = 4;
    localparam logic [15:0] SEED     = 16'hACE1;

    localparam int P_OFF  = 0;
    localparam int P_REL  = 1;
    localparam int P_ARM  = 2;
    localparam int P_TEL  = 3;
    localparam int P_COOL = 4;

    logic CLK = 1'b0;
    logic resetN;

    gate_scheduler_if bus ();

    gate_scheduler #(
        .PERIOD    (PERIOD),
        .COOLDOWN  (COOLDOWN),
        .LFSR_SEED (SEED)
    ) dut (
        .CLK    (CLK),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_phase   = P_OFF;
    int          m_elapsed = 0;
    logic [3:0]  m_rand    = 4'd0;
    logic        m_to_b    = 1'b0;
    logic [15:0] m_lfsr    = SEED;
    bit          m_started = 1'b0;
    int          collide_cnt = 0;
    int          wrap_cnt    = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic logic [3:0] pick_index(input logic [3:0] prev, input logic [3:0] c);
        int n;
        n = int'(c);
        if (c == prev) n = (n + 1) % 16;
        return 4'(n);
    endfunction

    // Reference model: phase plus the count of edges spent in the phase.
    always @(posedge CLK) begin : model
        int nxt;
        m_started = 1'b1;
        if (!resetN) begin
            m_phase   = P_OFF;
            m_elapsed = 0;
            m_rand    = 4'd0;
            m_to_b    = 1'b0;
            m_lfsr    = SEED;
        end else begin
            nxt = m_phase;
            m_elapsed++;
            if (m_phase == P_REL) begin
                if (m_lfsr[3:0] == m_rand) begin
                    collide_cnt++;
                    if (m_rand == 4'd15) wrap_cnt++;
                end
                m_rand = pick_index(m_rand, m_lfsr[3:0]);
            end
            if (m_phase != P_OFF && !bus.game_active) begin
                nxt = P_OFF;
            end else begin
                case (m_phase)
                    P_OFF:  if (bus.game_active) nxt = P_REL;
                    P_REL:  nxt = P_ARM;
                    P_ARM: begin
                        if (bus.hit_A) begin
                            nxt = P_TEL; m_to_b = 1'b1;
                        end else if (bus.hit_B) begin
                            nxt = P_TEL; m_to_b = 1'b0;
                        end else if (m_elapsed >= int'(PERIOD)) begin
                            nxt = P_REL;
                        end
                    end
                    P_TEL:  nxt = P_COOL;
                    P_COOL: if (m_elapsed >= int'(COOLDOWN) && !bus.hit_A && !bus.hit_B) nxt = P_REL;
                    default: nxt = P_OFF;
                endcase
            end
            if (nxt != m_phase) m_elapsed = 0;
            m_phase = nxt;
            m_lfsr  = lfsr_step(m_lfsr);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (m_started) begin
            checkOutput("model change_coord", bus.change_coord, int'(m_phase == P_REL && resetN));
            checkOutput("model teleport_req", bus.teleport_req, int'(m_phase == P_TEL && resetN));
            checkOutput("model gates_ready", bus.gates_ready, int'(m_phase == P_ARM && resetN));
            checkOutput("model random", int'(bus.random), int'(m_rand));
            checkOutput("model teleport_to_B", bus.teleport_to_B, int'(m_to_b));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ga, input logic ha, input logic hb, input logic rn);
        bus.game_active = ga;
        bus.hit_A       = ha;
        bus.hit_B       = hb;
        resetN          = rn;
    endtask

    // Wait for change_coord, bounded, and check how many cycles it took.
    task automatic waitRelocate(input string name, input int expected);
        int cnt;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus.change_coord !== 1'b1 && cnt < 40);
        checkOutput(name, cnt, expected);
    endtask

    initial begin : stimulus
        int prev;
        int tp;
        int ccn;
        applyStimulus(0, 0, 0, 0);

        checkOutput("pin lfsr step from seed", int'(lfsr_step(SEED)), 'hE270);
        checkOutput("pin index wrap 15->0", int'(pick_index(4'd15, 4'd15)), 0);
        checkOutput("pin index bump 3->4", int'(pick_index(4'd3, 4'd3)), 4);
        checkOutput("pin index keep", int'(pick_index(4'd5, 4'd9)), 9);

        // Reset held for three cycles
        repeat (3) begin
            tick();
            checkOutput("reset change_coord", bus.change_coord, 0);
            checkOutput("reset teleport_req", bus.teleport_req, 0);
            checkOutput("reset gates_ready", bus.gates_ready, 0);
            checkOutput("reset random", int'(bus.random), 0);
            checkOutput("reset teleport_to_B", bus.teleport_to_B, 0);
        end

        // Start a round
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("start change_coord", bus.change_coord, 1);
        checkOutput("start gates_ready", bus.gates_ready, 0);
        tick();
        checkOutput("start gates_ready next", bus.gates_ready, 1);
        checkOutput("start change_coord low", bus.change_coord, 0);
        checkOutput("first random bumped off 0", int'(bus.random), 1);

        // Idle relocations
        prev = int'(bus.random);
        for (int k = 0; k < 50; k++) begin
            waitRelocate("relocation interval", 8);
            tick();
            checkOutput("random differs from previous", int'(int'(bus.random) != prev), 1);
            prev = int'(bus.random);
        end
        $display("[TB] info: %0d index collisions seen, %0d of them wrapping 15->0", collide_cnt, wrap_cnt);

        // hit_A held for 10 cycles
        applyStimulus(1, 1, 0, 1);
        tp  = 0;
        ccn = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                checkOutput("hitA teleport_req", bus.teleport_req, 1);
                checkOutput("hitA teleport_to_B", bus.teleport_to_B, 1);
            end
            tp  += int'(bus.teleport_req);
            ccn += int'(bus.change_coord);
        end
        checkOutput("hitA single teleport", tp, 1);
        checkOutput("hitA no relocate while held", ccn, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("hitA relocate after release", bus.change_coord, 1);
        tick();

        // Both hits together
        applyStimulus(1, 1, 1, 1);
        tick();
        checkOutput("both teleport_req", bus.teleport_req, 1);
        checkOutput("both teleport_to_B", bus.teleport_to_B, 1);
        applyStimulus(1, 0, 0, 1);
        waitRelocate("teleport to relocate", 5);
        tick();

        // hit_B alone
        applyStimulus(1, 0, 1, 1);
        tick();
        checkOutput("hitB teleport_req", bus.teleport_req, 1);
        checkOutput("hitB teleport_to_B", bus.teleport_to_B, 0);
        applyStimulus(1, 0, 0, 1);
        waitRelocate("teleport to relocate", 5);
        tick();

        // Hit on the timer's final cycle
        repeat (7) tick();
        applyStimulus(1, 1, 0, 1);
        tick();
        checkOutput("timer-zero hit teleport_req", bus.teleport_req, 1);
        checkOutput("timer-zero hit change_coord", bus.change_coord, 0);
        applyStimulus(1, 0, 0, 1);
        waitRelocate("teleport to relocate", 5);
        tick();

        // game_active dropped during cooldown
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("drop gates_ready", bus.gates_ready, 0);
        tp = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tp += int'(bus.change_coord) + int'(bus.teleport_req);
        end
        checkOutput("drop no pulses", tp, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("restart change_coord", bus.change_coord, 1);
        tick();
        checkOutput("restart gates_ready", bus.gates_ready, 1);

        // Reset pulsed during ARMED
        repeat (2) tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("midreset gates_ready", bus.gates_ready, 0);
        checkOutput("midreset random", int'(bus.random), 0);
        checkOutput("midreset teleport_to_B", bus.teleport_to_B, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("post-reset change_coord", bus.change_coord, 1);
        tick();
        checkOutput("post-reset gates_ready", bus.gates_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_scheduler.md
Name: gate_scheduler

Overview:
- Controller that sequences the gate pair's life cycle: initial placement, periodic relocation, frog teleport on gate entry, post-teleport cooldown.
- Drives the gate mover's `change_coord` pulse and 4-bit `random` index. Emits a teleport request towards the frog controller.
- Sits between the collision logic (gate hit flags) and the gate mover; one instance per game.

Parameters:
- PERIOD, 250000000, cycles gates stay armed without use before forced relocation (5 s at 50 MHz).
- COOLDOWN, 25000000, cycles hits are ignored after a teleport (0.5 s).
- LFSR_SEED, 16'hACE1, reset value of internal LFSR; must be nonzero.

Ports:
- CLK  in  1  system clock, 50 MHz.
- resetN  in  1  reset.
- game_active  in  1  level; high while a game round is running.
- hit_A  in  1  level; frog overlaps gate A (may stay high many cycles).
- hit_B  in  1  level; frog overlaps gate B.
- random  out  4  gate position index to the gate mover; registered, stable between relocations.
- change_coord  out  1  one-cycle pulse requesting the gate mover to hide and re-place gates.
- teleport_req  out  1  one-cycle pulse; frog must jump to the exit gate.
- teleport_to_B  out  1  registered; 1 = entered A, exit B; 0 = entered B, exit A. Valid with teleport_req, held until the next teleport.
- gates_ready  out  1  high only in ARMED.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low: resetN low is sampled on the CLK rising edge.
- Reset values: state OFF, random=0, change_coord=0, teleport_req=0, teleport_to_B=0, gates_ready=0, timer=0, LFSR=LFSR_SEED.
- Timer is 28 bits, unsigned. Loads are PERIOD-1 or COOLDOWN-1. Decrements by 1 per cycle, saturating at 0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in every state except during reset.
- Index selection, evaluated only in RELOCATE:
  - cand = LFSR[3:0].
  - If cand == current random, new random = (cand+1) mod 16 (4-bit wrap, 15 -> 0). Otherwise new random = cand.
  - Consecutive placements therefore never repeat.
- random changes only on the RELOCATE edge. It is held otherwise, because the gate mover samples it late, after its hide window.
- States:
  - OFF: all pulses 0, gates_ready=0. If game_active=1 -> RELOCATE.
  - RELOCATE (1 cycle): change_coord=1; random updated as above; timer <= PERIOD-1; -> ARMED.
  - ARMED: gates_ready=1; timer decrements.
    - hit_A=1 -> TELEPORT with teleport_to_B <= 1.
    - else hit_B=1 -> TELEPORT with teleport_to_B <= 0. A wins if both hits are high in the same cycle.
    - else timer==0 -> RELOCATE.
    - A hit takes priority over timer expiry in the same cycle.
  - TELEPORT (1 cycle): teleport_req=1; timer <= COOLDOWN-1; -> COOLDOWN.
  - COOLDOWN: hits ignored; timer decrements.
    - When timer==0 and hit_A==0 and hit_B==0 -> RELOCATE (used gates always move).
    - If a hit is still high at timer==0, stay in COOLDOWN until both hits are low. No re-trigger.
- game_active low in any state except OFF -> OFF on the next edge.
  - Pulses in that cycle are computed from the current state, so a RELOCATE/TELEPORT cycle still emits its pulse.
  - Timer is cleared in OFF; random is held.
- Outputs change_coord and teleport_req are Moore outputs of states RELOCATE and TELEPORT (combinational decode of the state register, glitch-free, exactly one cycle each).
- Latency:
  - game_active rise to change_coord: 1 cycle.
  - First hit cycle in ARMED to teleport_req: 1 cycle.
  - teleport_req to change_coord: COOLDOWN+1 cycles minimum.
- Reset mid-operation returns to OFF regardless of state. No pulse is emitted in the reset cycle.

Test Plan (PERIOD=8, COOLDOWN=4, LFSR_SEED=16'hACE1):
- Reset held 3 cycles, then game_active=1 -> all outputs 0 during reset; change_coord high exactly 1 cycle after game_active sampled; random != 0 if LFSR[3:0]==0 rule applied; gates_ready high next cycle.
- Idle ARMED with no hits -> change_coord pulses every 9 cycles (RELOCATE + 8 ARMED). Over 50 relocations, no two consecutive random values are equal. Force cand==prev, including prev=15 -> random=0.
- hit_A raised for 10 cycles in ARMED -> teleport_req one cycle later with teleport_to_B=1. Exactly one teleport_req. change_coord only after hit_A falls and 4 cooldown cycles have elapsed.
- hit_A and hit_B raised same cycle -> teleport_to_B=1. Then hit_B alone on the next round -> teleport_to_B=0.
- Hit arriving on the same cycle the timer reaches 0 -> TELEPORT taken, no change_coord that cycle.
- game_active dropped during COOLDOWN, and resetN pulsed low during ARMED -> OFF next edge, gates_ready=0, no further pulses; re-raising game_active restarts with RELOCATE.
